// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_pkg
// Purpose  : Shared stall-vector layout, stall patterns and controller FSM
//            state encodings for the 5-stage pipeline controller.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

   // Bit positions inside the per-stage stall vector
   localparam int STALL_PC  = 0;
   localparam int STALL_IF  = 1;
   localparam int STALL_ID  = 2;
   localparam int STALL_EX  = 3;
   localparam int STALL_MEM = 4;
   localparam int STALL_WB  = 5;

   // Stall patterns: a load-use hazard freezes the front end and bubbles EX,
   // a multi-cycle op additionally holds EX itself.
   localparam logic [5:0] STALL_NONE = 6'b000000;
   localparam logic [5:0] STALL_LUSE = (6'b1 << STALL_PC) | (6'b1 << STALL_IF)
                                     | (6'b1 << STALL_ID);
   localparam logic [5:0] STALL_MC   = STALL_LUSE | (6'b1 << STALL_EX);

   // Controller FSM encodings (visible on state_o)
   typedef enum logic [1:0] {
      PC_IDLE  = 2'd0,
      PC_BUSY  = 2'd1,
      PC_ABORT = 2'd2
   } pc_state_t;

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module   : hazard_detect
// Purpose  : Combinational load-use compare between the two ID read ports and
//            the destination of a load currently in EX. $0 never matches.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_detect (
   input  logic       id_reg1_read,
   input  logic [4:0] id_reg1_addr,
   input  logic       id_reg2_read,
   input  logic [4:0] id_reg2_addr,
   input  logic       ex_wreg,
   input  logic [4:0] ex_wd,
   input  logic       ex_is_load,
   output logic       luse
);

   logic load_dst_live;
   logic port1_hit;
   logic port2_hit;

   // A load only creates a hazard if it really writes a non-zero register,
   // and only for an ID port that actually reads that register.
   always_comb begin
      load_dst_live = ex_is_load && ex_wreg && (ex_wd != 5'd0);
      port1_hit     = id_reg1_read && (id_reg1_addr == ex_wd);
      port2_hit     = id_reg2_read && (id_reg2_addr == ex_wd);
      luse          = load_dst_live && (port1_hit || port2_hit);
   end

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl
// Purpose  : Pipeline controller - stall vector generation, load-use stalls,
//            multi-cycle EX sequencing with timeout, flush priority and a
//            saturating stall-cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MC_TIMEOUT = 64,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_reg1_read,
   input  logic [4:0]       id_reg1_addr,
   input  logic             id_reg2_read,
   input  logic [4:0]       id_reg2_addr,
   input  logic             ex_wreg,
   input  logic [4:0]       ex_wd,
   input  logic             ex_is_load,
   input  logic             mc_start,
   input  logic             mc_done,
   input  logic             flush_req,
   output logic [5:0]       stall_o,
   output logic             flush_o,
   output logic             mc_abort_o,
   output logic [1:0]       state_o,
   output logic [CNT_W-1:0] stall_cnt_o
);

   // Timer counts 0..MC_TIMEOUT-1 while BUSY
   localparam int             TMR_W    = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MC_TIMEOUT - 1);

   pc_state_t        state;
   logic [TMR_W-1:0] timer;
   logic [CNT_W-1:0] stall_cnt;
   logic             luse;
   logic [5:0]       stall;
   logic             flush;
   logic             abort;

   hazard_detect u_hazard_detect (
      .id_reg1_read (id_reg1_read),
      .id_reg1_addr (id_reg1_addr),
      .id_reg2_read (id_reg2_read),
      .id_reg2_addr (id_reg2_addr),
      .ex_wreg      (ex_wreg),
      .ex_wd        (ex_wd),
      .ex_is_load   (ex_is_load),
      .luse         (luse)
   );

   // Output mux with priority rst > flush > FSM > load-use
   always_comb begin
      stall = STALL_NONE;
      flush = 1'b0;
      abort = 1'b0;
      if (rst) begin
         stall = STALL_NONE;
      end else if (flush_req) begin
         flush = 1'b1;
         abort = (state == PC_BUSY);
      end else begin
         case (state)
            PC_IDLE:  stall = mc_start ? STALL_MC : (luse ? STALL_LUSE : STALL_NONE);
            PC_BUSY:  stall = mc_done ? STALL_NONE : STALL_MC;
            PC_ABORT: begin
               stall = STALL_MC;
               abort = 1'b1;
            end
            default:  stall = luse ? STALL_LUSE : STALL_NONE;
         endcase
      end
   end

   // Multi-cycle sequencing FSM and its timeout timer
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= PC_IDLE;
         timer <= '0;
      end else begin
         case (state)
            PC_IDLE: begin
               if (!flush_req && mc_start) begin
                  state <= PC_BUSY;
                  timer <= '0;
               end
            end
            PC_BUSY: begin
               if (flush_req || mc_done) begin
                  state <= PC_IDLE;
               end else if (timer == TMR_LAST) begin
                  state <= PC_ABORT;
               end else begin
                  timer <= timer + TMR_W'(1);
               end
            end
            PC_ABORT: state <= PC_IDLE;
            default:  state <= PC_IDLE;
         endcase
      end
   end

   // Saturating count of cycles in which any stage is stalled
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if ((stall != STALL_NONE) && (stall_cnt != {CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

   assign stall_o     = stall;
   assign flush_o     = flush;
   assign mc_abort_o  = abort;
   assign state_o     = state;
   assign stall_cnt_o = stall_cnt;

endmodule
`default_nettype wire

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline controller for the 5-stage integer core.
- Generates the per-stage stall vector for PC, IF, ID, EX, MEM and WB.
- Detects load-use hazards between the ID read ports and the load in EX.
- Sequences multi-cycle EX operations (mult/div) with a timeout, and prioritises flush requests over all stalls.

Parameters:
- MC_TIMEOUT, 64, max BUSY cycles before a multi-cycle op is aborted; legal range 2..256.
- CNT_W, 32, width of the stall-cycle performance counter.

Ports:
- clk  in  1  core clock
- rst  in  1  reset; synchronous, active-high
- id_reg1_read  in  1  ID reads operand 1 from regfile
- id_reg1_addr  in  5  ID operand 1 register address
- id_reg2_read  in  1  ID reads operand 2 from regfile
- id_reg2_addr  in  5  ID operand 2 register address
- ex_wreg  in  1  instruction in EX writes a destination register
- ex_wd  in  5  EX destination register address
- ex_is_load  in  1  instruction in EX is a load
- mc_start  in  1  EX begins a multi-cycle operation (1-cycle pulse)
- mc_done  in  1  multi-cycle unit result valid (1-cycle pulse)
- flush_req  in  1  exception/branch flush request
- stall_o  out  6  stall vector: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB
- flush_o  out  1  flush all stage registers this cycle
- mc_abort_o  out  1  kill the in-flight multi-cycle op
- state_o  out  2  FSM state: 0 IDLE, 1 BUSY, 2 ABORT
- stall_cnt_o  out  CNT_W  count of cycles with stall_o != 0

Behaviour:
- Reset (cycle with rst=1):
  - state=IDLE, timer=0, stall_cnt=0.
  - stall_o=0, flush_o=0, mc_abort_o=0, state_o=0.
  - rst overrides all inputs, including mid-BUSY; no abort pulse is emitted.
- Load-use hazard (luse) is combinational, asserted when all of:
  - ex_is_load, ex_wreg, and ex_wd != 0;
  - and (id_reg1_read with id_reg1_addr==ex_wd) or (id_reg2_read with id_reg2_addr==ex_wd).
- Stall patterns:
  - LUSE = 6'b000111: PC, IF, ID hold; EX receives a bubble.
  - MC = 6'b001111: PC through EX hold.
  - NONE = 0.
- FSM states and transitions:
  - IDLE:
    - flush_req -> stay IDLE.
    - else mc_start -> BUSY, timer cleared to 0.
    - mc_done is ignored.
  - BUSY:
    - flush_req -> IDLE.
    - else mc_done -> IDLE.
    - else timer==MC_TIMEOUT-1 -> ABORT.
    - else timer+1.
    - mc_start is ignored while BUSY.
  - ABORT: unconditionally -> IDLE after one cycle.
- Output priority within a cycle: rst > flush_req > FSM > luse.
  - flush_req=1: flush_o=1, stall_o=NONE. If state=BUSY, mc_abort_o=1 that cycle.
  - IDLE with mc_start: stall_o=MC, so EX holds in the start cycle.
  - BUSY with mc_done: stall_o=NONE in that cycle (result captured, pipeline advances).
  - BUSY without mc_done: stall_o=MC.
  - ABORT: stall_o=MC, mc_abort_o=1.
  - Otherwise: stall_o=LUSE if luse, else NONE.
- stall_o, flush_o and mc_abort_o are combinational from state and inputs; state, timer and counter are registered.
- stall_cnt: increments on every cycle with stall_o != 0 and saturates at all-ones (no wrap).
- A flush pending in the same cycle as mc_done in BUSY takes the flush path: mc_abort_o=1 and the result is discarded.
- Register $0 never causes a load-use stall.

Decomposition:
- Shared defines file holds:
  - stall bit indices (STALL_PC..STALL_WB);
  - stall patterns STALL_NONE, STALL_LUSE, STALL_MC;
  - FSM state encodings PC_IDLE, PC_BUSY, PC_ABORT.
- One natural sub-module: hazard_detect, a pure combinational luse compare over the ID read ports and the EX destination.
- pipe_ctrl instantiates hazard_detect and owns the FSM, timer, counter and output muxing.

Test Plan:
- Reset: rst=1 for 2 cycles during BUSY with timer=10 -> state_o=0, stall_o=0, stall_cnt_o=0, mc_abort_o never asserted.
- Load-use:
  - ex_is_load=1, ex_wreg=1, ex_wd=5, id_reg2_read=1, id_reg2_addr=5 -> stall_o=6'b000111 for one cycle.
  - Same with ex_wd=0 -> stall_o=0.
- Multi-cycle normal: mc_start at cycle 0, mc_done at cycle 6 -> stall_o=6'b001111 for cycles 0..5, stall_o=0 at cycle 6, state_o back to 0 at cycle 7, stall_cnt_o=6.
- Timeout: MC_TIMEOUT=4, mc_start, no mc_done -> BUSY cycles 1..4, ABORT at cycle 5 with mc_abort_o=1 and stall_o=6'b001111, IDLE at cycle 6.
- Flush priority:
  - flush_req in BUSY with a simultaneous luse -> flush_o=1, stall_o=0, mc_abort_o=1, next state IDLE.
  - mc_start in the same cycle as flush_req from IDLE -> stays IDLE.
- Counter saturation: CNT_W=3, hold luse for 10 cycles -> stall_cnt_o stops at 7.
